// File: rtl/preg_freelist.sv
// Physical register free list for the rename stage.
// Circular buffer of free preg ids with three pointers:
//   commit_head .. spec_head : ids handed out but not yet committed
//   spec_head   .. tail      : ids available for allocation
// A flush rewinds spec_head to commit_head, returning every uncommitted id.
// After reset the buffer is filled with ids 0..PRFSIZE-1, one per cycle.
module preg_freelist #(
   parameter int unsigned PRFSIZE      = 64,
   parameter int unsigned PREG_ID_BITS = $clog2(PRFSIZE)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alloc_req,
   output logic                    alloc_ready,
   output logic [PREG_ID_BITS-1:0] alloc_preg,
   input  logic                    commit_valid,
   input  logic                    free_valid,
   input  logic [PREG_ID_BITS-1:0] free_preg,
   input  logic                    flush,
   output logic [PREG_ID_BITS:0]   free_count,
   output logic                    init_done
);

   localparam int unsigned PTR_W = PREG_ID_BITS + 1;
   localparam logic [PREG_ID_BITS-1:0] LAST_IDX = PREG_ID_BITS'(PRFSIZE - 1);
   localparam logic [PTR_W-1:0]        FULL_PTR = PTR_W'(PRFSIZE);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [PREG_ID_BITS-1:0] init_cnt_q, init_cnt_d;
   logic [PTR_W-1:0]        spec_head_q, spec_head_d;
   logic [PTR_W-1:0]        commit_head_q, commit_head_d;
   logic [PTR_W-1:0]        tail_q, tail_d;
   logic [PREG_ID_BITS-1:0] mem_q [PRFSIZE];

   logic                    run;
   logic [PTR_W-1:0]        avail_cnt;
   logic [PTR_W-1:0]        live_cnt;
   logic [PTR_W-1:0]        spec_cnt;
   logic                    alloc_fire;
   logic                    commit_ok;
   logic                    free_ok;
   logic                    mem_we;
   logic [PREG_ID_BITS-1:0] mem_waddr;
   logic [PREG_ID_BITS-1:0] mem_wdata;

   // Occupancy figures derived from the registered pointers (wrap-safe subtraction).
   always_comb begin
      run       = (state_q == ST_RUN);
      avail_cnt = tail_q - spec_head_q;
      live_cnt  = tail_q - commit_head_q;
      spec_cnt  = spec_head_q - commit_head_q;
   end

   // Allocation handshake; no allocation is offered during a flush cycle.
   always_comb begin
      free_count  = run ? avail_cnt : '0;
      init_done   = run;
      alloc_ready = run && (avail_cnt != '0) && !flush;
      alloc_preg  = mem_q[spec_head_q[PREG_ID_BITS-1:0]];
      alloc_fire  = alloc_req && alloc_ready;
   end

   // Illegal commit (nothing outstanding) and illegal free (buffer full) are dropped.
   always_comb begin
      commit_ok = run && commit_valid && (commit_head_q != spec_head_q);
      free_ok   = run && free_valid && (live_cnt != FULL_PTR);
   end

   // Next-state logic: init fill sequence, then pointer updates while running.
   always_comb begin
      state_d       = state_q;
      init_cnt_d    = init_cnt_q;
      spec_head_d   = spec_head_q;
      commit_head_d = commit_head_q;
      tail_d        = tail_q;
      mem_we        = 1'b0;
      mem_waddr     = '0;
      mem_wdata     = '0;

      case (state_q)
         ST_INIT: begin
            mem_we     = 1'b1;
            mem_waddr  = init_cnt_q;
            mem_wdata  = init_cnt_q;
            init_cnt_d = init_cnt_q + PREG_ID_BITS'(1);
            if (init_cnt_q == LAST_IDX) begin
               state_d       = ST_RUN;
               spec_head_d   = '0;
               commit_head_d = '0;
               tail_d        = FULL_PTR;
            end
         end

         ST_RUN: begin
            if (alloc_fire) begin
               spec_head_d = spec_head_q + PTR_W'(1);
            end
            if (commit_ok) begin
               commit_head_d = commit_head_q + PTR_W'(1);
            end
            if (free_ok) begin
               mem_we    = 1'b1;
               mem_waddr = tail_q[PREG_ID_BITS-1:0];
               mem_wdata = free_preg;
               tail_d    = tail_q + PTR_W'(1);
            end
            // Flush rewinds to the commit point, including a same-cycle commit.
            if (flush) begin
               spec_head_d = commit_head_d;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_INIT;
         init_cnt_q    <= '0;
         spec_head_q   <= '0;
         commit_head_q <= '0;
         tail_q        <= '0;
      end else begin
         state_q       <= state_d;
         init_cnt_q    <= init_cnt_d;
         spec_head_q   <= spec_head_d;
         commit_head_q <= commit_head_d;
         tail_q        <= tail_d;
      end
   end

   // Id storage; contents survive reset and are rewritten by the init sequence.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Protocol checks: commit with nothing outstanding, free into a full buffer.
   a_commit_legal : assert property (@(posedge clk) disable iff (rst)
      (run && commit_valid) |-> (commit_head_q != spec_head_q));

   a_free_legal : assert property (@(posedge clk) disable iff (rst)
      (run && free_valid) |-> (live_cnt != FULL_PTR));

   // Pointer ordering: commit_head <= spec_head <= tail, at most PRFSIZE live entries.
   a_ptr_order : assert property (@(posedge clk) disable iff (rst)
      run |-> ((spec_cnt <= live_cnt) && (live_cnt <= FULL_PTR)));

endmodule

// File: tb/tb_preg_freelist.sv
// Randomized and directed bench for preg_freelist against a queue-based model:
// free_l holds allocatable ids in hand-out order, spec_l the uncommitted
// allocations in program order, live_l the committed ids not yet released.
module tb_preg_freelist;

   localparam int unsigned N   = 64;
   localparam int unsigned IDW = 6;

   logic           clk = 1'b0;
   logic           rst;
   logic           alloc_req;
   logic           alloc_ready;
   logic [IDW-1:0] alloc_preg;
   logic           commit_valid;
   logic           free_valid;
   logic [IDW-1:0] free_preg;
   logic           flush;
   logic [IDW:0]   free_count;
   logic           init_done;

   int n_tests = 0;
   int n_fail  = 0;

   int free_l[$];
   int spec_l[$];
   int live_l[$];

   always #5 clk = ~clk;

   preg_freelist #(.PRFSIZE(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_ready  (alloc_ready),
      .alloc_preg   (alloc_preg),
      .commit_valid (commit_valid),
      .free_valid   (free_valid),
      .free_preg    (free_preg),
      .flush        (flush),
      .free_count   (free_count),
      .init_done    (init_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit in_use(input int id);
      foreach (spec_l[k]) if (spec_l[k] == id) return 1'b1;
      foreach (live_l[k]) if (live_l[k] == id) return 1'b1;
      return 1'b0;
   endfunction

   // One RUN cycle: drive, compare outputs with the model, clock, update the model.
   task automatic step(input bit a, input bit c, input bit fv, input int fid, input bit fl);
      bit can_alloc;
      alloc_req    = a;
      commit_valid = c;
      free_valid   = fv;
      free_preg    = IDW'(fid);
      flush        = fl;
      can_alloc    = (free_l.size() != 0) && !fl;
      @(negedge clk);
      check_eq("init_done", 32'(init_done), 32'd1);
      check_eq("free_count", 32'(free_count), 32'(free_l.size()));
      check_eq("alloc_ready", 32'(alloc_ready), 32'(can_alloc));
      if (can_alloc) begin
         check_eq("alloc_preg", 32'(alloc_preg), 32'(free_l[0]));
         if (a) check_eq("id_not_live", 32'(in_use(int'(alloc_preg))), 32'd0);
      end
      @(posedge clk);
      if (a && can_alloc) spec_l.push_back(free_l.pop_front());
      if (c) live_l.push_back(spec_l.pop_front());
      if (fl) while (spec_l.size() != 0) free_l.push_front(spec_l.pop_back());
      if (fv) begin
         for (int k = 0; k < live_l.size(); k++) begin
            if (live_l[k] == fid) begin
               live_l.delete(k);
               break;
            end
         end
         free_l.push_back(fid);
      end
      #1;
      alloc_req    = 1'b0;
      commit_valid = 1'b0;
      free_valid   = 1'b0;
      flush        = 1'b0;
   endtask

   // Hold reset for a few cycles and check the reset-state outputs.
   task automatic do_reset(input int hold);
      rst          = 1'b1;
      alloc_req    = 1'b0;
      commit_valid = 1'b0;
      free_valid   = 1'b0;
      flush        = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(alloc_ready), 32'd0);
      check_eq("rst_done", 32'(init_done), 32'd0);
      check_eq("rst_fcount", 32'(free_count), 32'd0);
      repeat (hold) @(posedge clk);
      #1;
   endtask

   // Release reset and walk through the fill sequence with traffic that must be ignored.
   task automatic wait_init();
      rst          = 1'b0;
      alloc_req    = 1'b1;
      commit_valid = 1'b1;
      free_valid   = 1'b1;
      free_preg    = IDW'(7);
      for (int i = 1; i <= int'(N); i++) begin
         @(posedge clk);
         #1;
         if (i == 10) begin
            check_eq("init_fcount", 32'(free_count), 32'd0);
            check_eq("init_ready", 32'(alloc_ready), 32'd0);
         end
         if (i == int'(N) - 1) check_eq("init_done_early", 32'(init_done), 32'd0);
      end
      check_eq("init_done_rise", 32'(init_done), 32'd1);
      alloc_req    = 1'b0;
      commit_valid = 1'b0;
      free_valid   = 1'b0;
      free_l.delete();
      spec_l.delete();
      live_l.delete();
      for (int i = 0; i < int'(N); i++) free_l.push_back(i);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1 (finished)");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst          = 1'b1;
      alloc_req    = 1'b0;
      commit_valid = 1'b0;
      free_valid   = 1'b0;
      free_preg    = '0;
      flush        = 1'b0;

      do_reset(3);
      wait_init();

      // Back-to-back allocations straight after init.
      for (int i = 0; i < 4; i++) begin
         check_eq("b2b_id", 32'(alloc_preg), 32'(i));
         step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      end
      check_eq("fc_after4", 32'(free_count), 32'd60);

      // Ten outstanding, then reset mid-run.
      repeat (6) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check_eq("pre_rst_fc", 32'(free_count), 32'd54);
      do_reset(2);
      wait_init();
      check_eq("post_rst_id", 32'(alloc_preg), 32'd0);

      // Allocate six, commit two, flush.
      repeat (6) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      check_eq("flush_fc", 32'(free_count), 32'd62);
      check_eq("flush_id", 32'(alloc_preg), 32'd2);

      // Flush with a same-cycle commit and alloc request.
      repeat (3) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      check_eq("flcm_fc", 32'(free_count), 32'd61);
      check_eq("flcm_id", 32'(alloc_preg), 32'd3);

      // Drain the list completely, hold requests, commit all, release preg 5.
      for (int i = 0; i < int'(N) && free_l.size() != 0; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check_eq("full_ready", 32'(alloc_ready), 32'd0);
      check_eq("full_fc", 32'(free_count), 32'd0);
      step(1'b1, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < int'(N) && spec_l.size() != 0; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5, 1'b0);
      check_eq("freed5_ready", 32'(alloc_ready), 32'd1);
      check_eq("freed5_id", 32'(alloc_preg), 32'd5);

      // Random alloc/commit/free/flush traffic recycling ids.
      for (int i = 0; i < 300; i++) begin
         bit a, c, fv, fl;
         int fid;
         a   = ($urandom % 4) != 0;
         c   = (spec_l.size() != 0) && (($urandom % 3) != 0);
         fv  = (live_l.size() != 0) && (($urandom % 3) != 0);
         fid = fv ? live_l[$urandom_range(0, live_l.size() - 1)] : 0;
         fl  = ($urandom % 16) == 0;
         step(a, c, fv, fid, fl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 Parameter PRFSIZE, default 64, number of physical registers (power of two, >=4).
REQ-002 Parameter PREG_ID_BITS, default $clog2(PRFSIZE), physical register id width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alloc_req  input  1  rename stage requests one preg this cycle.
REQ-006 alloc_ready  output  1  a free preg is available and alloc_preg is valid.
REQ-007 alloc_preg  output  PREG_ID_BITS  preg id handed out when alloc_req && alloc_ready.
REQ-008 commit_valid  input  1  oldest preg-allocating instruction committed; its allocation becomes non-speculative.
REQ-009 free_valid  input  1  a preg is released at commit.
REQ-010 free_preg  input  PREG_ID_BITS  id of the released preg.
REQ-011 flush  input  1  squash all uncommitted allocations.
REQ-012 free_count  output  PREG_ID_BITS+1  number of pregs currently allocatable.
REQ-013 init_done  output  1  high once initialisation has completed.

Function
REQ-014 Storage: circular buffer mem[PRFSIZE] of preg ids; pointers spec_head, commit_head and tail, each PREG_ID_BITS+1 bits (MSB is wrap bit); index = low PREG_ID_BITS bits.
REQ-015 FSM states INIT and RUN; rst forces INIT.
REQ-016 INIT: one write per cycle, mem[i] <= i, for i = 0..PRFSIZE-1, using an internal counter; after the write of PRFSIZE-1, next state RUN.
REQ-017 On entering RUN: spec_head = commit_head = 0; tail = PRFSIZE (wrapped to index 0, wrap bit 1).
REQ-018 In INIT: alloc_ready = 0, init_done = 0, free_count = 0; commit_valid, free_valid and flush are ignored.
REQ-019 free_count = tail - spec_head, computed from registered pointers.
REQ-020 alloc_ready = RUN && free_count != 0 && !flush.
REQ-021 alloc_preg = mem[spec_head index], combinational; content is don't-care when alloc_ready = 0.
REQ-022 Allocate fire (alloc_req && alloc_ready): spec_head += 1 next cycle; zero-cycle latency from request to id.
REQ-023 Commit (commit_valid, RUN): commit_head += 1; commit_valid when commit_head == spec_head is illegal: simulation assertion fires and commit_head is held.
REQ-024 Free (free_valid, RUN): mem[tail index] <= free_preg; tail += 1; free_valid when tail - commit_head == PRFSIZE is illegal: simulation assertion fires and the write is dropped.
REQ-025 No free-to-alloc bypass: a preg freed in cycle N is allocatable no earlier than cycle N+1.
REQ-026 Flush (RUN): spec_head <= commit_head_next, where commit_head_next includes a same-cycle commit; a same-cycle free still takes effect; no allocation fires in the flush cycle.
REQ-027 Allocate, commit and free in the same cycle all take effect independently.
REQ-028 Pointer arithmetic is modulo 2*PRFSIZE; wrap-around needs no special case.
REQ-029 Invariant, asserted every RUN cycle: commit_head <= spec_head <= tail in wrap order, and tail - commit_head <= PRFSIZE.
REQ-030 init_done = 1 exactly when state is RUN.

Reset
REQ-031 While rst = 1 at a posedge: state INIT, init counter 0, all pointers 0, alloc_ready 0, init_done 0, free_count 0; mem is not cleared.
REQ-032 rst asserted mid-operation discards all allocations and reruns the full PRFSIZE-cycle INIT.

Verification
REQ-033 Release rst -> init_done rises after exactly 64 cycles; then 4 back-to-back allocs return 0,1,2,3 and free_count reads 60.
REQ-034 Allocate 64 with no frees -> alloc_ready = 0 and free_count = 0; alloc_req held high -> no fire; free preg 5 -> alloc_ready high next cycle, alloc_preg = 5.
REQ-035 Allocate 0..5, commit 2 of them, flush -> free_count = 62 next cycle, next alloc returns 2.
REQ-036 Flush with a same-cycle commit and alloc_req -> no fire that cycle; spec_head = old commit_head + 1.
REQ-037 Run 300 alloc/commit/free cycles recycling ids -> pointers wrap, no id is handed out twice while live, every invariant assertion holds.
REQ-038 Assert rst during RUN with 10 pregs allocated -> alloc_ready drops the next cycle, INIT reruns for 64 cycles, first alloc returns 0.
